// File: rtl/codec_config_sequencer.sv
// Codec power-up sequencer: walks a command table over the shared SPI controller, then grants it to a host port.
// Build option CONFIG_TABLE_SENTINEL_EN: an all-ones table word ends the table early without an SPI transaction.
module codec_config_sequencer #(
    parameter int NUM_CMDS       = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int GAP_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SPI_DATA_WIDTH = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    output logic [ADDR_WIDTH-1:0]     o_table_addr,
    input  logic [SPI_DATA_WIDTH-1:0] i_table_data,
    input  logic                      i_host_valid,
    output logic                      o_host_ready,
    input  logic [SPI_DATA_WIDTH-1:0] i_host_data,
    output logic                      o_spi_valid,
    input  logic                      i_spi_ready,
    output logic [SPI_DATA_WIDTH-1:0] o_spi_data,
    input  logic                      i_spi_done,
    output logic                      o_busy,
    output logic                      o_config_done,
    output logic                      o_error
);

    // state      | meaning
    // IDLE       | after reset, waits for i_start
    // FETCH      | table address out, word latched at end of cycle
    // ISSUE      | table word offered to SPI controller
    // WAIT_DONE  | waits for i_spi_done, timeout armed
    // GAP        | inter-command idle time (shared by table and host)
    // READY      | table done, host port open
    // HOST_ISSUE | host word offered to SPI controller
    // HOST_WAIT  | waits for i_spi_done of host word
    // FAULT      | done timeout, waits for i_start
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_DONE, S_GAP,
        S_READY, S_HOST_ISSUE, S_HOST_WAIT, S_FAULT
    } state_t;

    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]      TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]      GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CMDS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] index;
    logic [TMR_W-1:0]      timer;
    logic                  host_txn;
    logic                  start_ok;
    logic                  sentinel_hit;

    assign o_table_addr = index;
    assign start_ok = i_start && (state == S_IDLE || state == S_READY || state == S_FAULT);

`ifdef CONFIG_TABLE_SENTINEL_EN
    assign sentinel_hit = (i_table_data == {SPI_DATA_WIDTH{1'b1}});
`else
    assign sentinel_hit = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            index         <= '0;
            timer         <= '0;
            host_txn      <= 1'b0;
            o_spi_valid   <= 1'b0;
            o_spi_data    <= '0;
            o_host_ready  <= 1'b0;
            o_busy        <= 1'b0;
            o_config_done <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_host_ready <= 1'b0;
            if (start_ok) begin
                state         <= S_FETCH;
                index         <= '0;
                host_txn      <= 1'b0;
                o_busy        <= 1'b1;
                o_config_done <= 1'b0;
                o_error       <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (sentinel_hit) begin
                            state         <= S_READY;
                            o_busy        <= 1'b0;
                            o_config_done <= 1'b1;
                        end else begin
                            o_spi_data  <= i_table_data;
                            o_spi_valid <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                    S_ISSUE, S_HOST_ISSUE: begin
                        if (i_spi_ready) begin
                            o_spi_valid <= 1'b0;
                            timer       <= TMO_LOAD;
                            state       <= (state == S_ISSUE) ? S_WAIT_DONE : S_HOST_WAIT;
                        end
                    end
                    S_WAIT_DONE, S_HOST_WAIT: begin
                        if (i_spi_done) begin
                            timer <= GAP_LOAD;
                            state <= S_GAP;
                        end else if (timer == '0) begin
                            state   <= S_FAULT;
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (timer != '0) begin
                            timer <= timer - TMR_W'(1);
                        end else if (host_txn) begin
                            host_txn <= 1'b0;
                            o_busy   <= 1'b0;
                            state    <= S_READY;
                        end else if (index == LAST_IDX) begin
                            o_busy        <= 1'b0;
                            o_config_done <= 1'b1;
                            state         <= S_READY;
                        end else begin
                            index <= index + ADDR_WIDTH'(1);
                            state <= S_FETCH;
                        end
                    end
                    S_READY: begin
                        // i_start has priority here; a colliding host request is simply not acked
                        if (i_host_valid) begin
                            o_host_ready <= 1'b1;
                            o_spi_data   <= i_host_data;
                            o_spi_valid  <= 1'b1;
                            o_busy       <= 1'b1;
                            host_txn     <= 1'b1;
                            state        <= S_HOST_ISSUE;
                        end
                    end
                    S_IDLE, S_FAULT: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
